// File: rtl/overlap_pkg.sv
// Shared types for the sequential overlap accumulator: beat index, FSM state
// and the number of sub-product beats that make up one result.
package overlap_pkg;

   localparam int NBEATS = 4;

   typedef enum logic [1:0] {
      BEAT_P1 = 2'd0,
      BEAT_P2 = 2'd1,
      BEAT_P3 = 2'd2,
      BEAT_P4 = 2'd3
   } beat_t;

   typedef enum logic {
      ST_ACC  = 1'b0,
      ST_DONE = 1'b1
   } state_t;

endpackage

// File: rtl/overlap_spread.sv
// Combinational spreader: places one W-bit sub-product onto the (2W+1)-bit
// overlap grid at the bit positions selected by its beat index.
module overlap_spread
   import overlap_pkg::*;
#(
   parameter int W = 33
) (
   input  logic [W-1:0] beat,
   input  beat_t        index,
   output logic [2*W:0] spread
);

   always_comb begin
      spread = '0;
      for (int i = 0; i < W; i++) begin
         case (index)
            BEAT_P1:          spread[2*i]     = beat[i];
            BEAT_P2, BEAT_P3: spread[2*i + 1] = beat[i];
            default:          spread[2*i + 2] = beat[i];
         endcase
      end
   end

endmodule

// File: rtl/overlap_accum_seq.sv
// Sequential overlap stage: accepts P1..P4 as W-bit beats, XOR-accumulates
// them into a (2W+1)-bit result. Define OVERLAP_PARITY_EN to add out_parity.
module overlap_accum_seq
   import overlap_pkg::*;
#(
   parameter int W = 33
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   in_data,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*W:0]   out_data,
   output logic           busy
`ifdef OVERLAP_PARITY_EN
   ,
   output logic           out_parity
`endif
);

   // Handshake: a beat or result moves on a rising edge exactly when its
   // valid and ready are both high; valid is never withdrawn by this block
   // until the transfer happens, and in_ready opens in DONE only via out_ready.

   localparam beat_t LAST_BEAT = beat_t'(NBEATS - 1);

   state_t         state, state_next;
   beat_t          count, count_next;
   logic [2*W:0]   acc, acc_next, acc_sum;
   logic [2*W:0]   spread_vec;
   logic           accept;
   logic           load_result;

   overlap_spread #(.W(W)) u_spread (
      .beat   (in_data),
      .index  (count),
      .spread (spread_vec)
   );

   assign in_ready  = (state == ST_ACC) || out_ready;
   assign out_valid = (state == ST_DONE);
   assign busy      = (state == ST_DONE) || (count != BEAT_P1);
   assign accept    = in_valid && in_ready;

   // P1 starts a fresh product, so the old accumulator is dropped rather than XORed.
   assign acc_sum = ((count == BEAT_P1) ? '0 : acc) ^ spread_vec;

   always_comb begin
      state_next  = state;
      count_next  = count;
      acc_next    = acc;
      load_result = 1'b0;
      case (state)
         ST_ACC: begin
            if (accept) begin
               acc_next = acc_sum;
               if (count == LAST_BEAT) begin
                  state_next  = ST_DONE;
                  count_next  = BEAT_P1;
                  load_result = 1'b1;
               end else begin
                  count_next = beat_t'(count + 2'd1);
               end
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_next = ST_ACC;
               // count is BEAT_P1 here, so a same-cycle beat becomes P1 of the next product
               if (in_valid) begin
                  acc_next   = acc_sum;
                  count_next = BEAT_P2;
               end
            end
         end
         default: begin
            state_next = ST_ACC;
            count_next = BEAT_P1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_ACC;
         count <= BEAT_P1;
         acc   <= '0;
      end else begin
         state <= state_next;
         count <= count_next;
         acc   <= acc_next;
      end
   end

   // Result register keeps the last finished product visible while the next one builds.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data <= '0;
      end else if (load_result) begin
         out_data <= acc_next;
      end
   end

`ifdef OVERLAP_PARITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_parity <= 1'b0;
      end else if (load_result) begin
         out_parity <= ^acc_next;
      end
   end
`endif

endmodule
